hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: `clk`  in  1  rising-edge clock.
REQ-002 SHALL have `reset`  in  1  asynchronous, active-high reset.
REQ-003 SHALL have `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction reads that source (jr sets only `id_uses_rs`).
REQ-005 SHALL have `id_reg_write`, `id_mem_read`  in  1 each  decoded RegWrite/MemRead of the ID instruction.
REQ-006 SHALL have `id_write_reg`  in  5  final destination after RegDst/Jal selection (31 for jal).
REQ-007 SHALL have `id_jump`, `id_jr`  in  1 each  decoded j/jal and jr flags.
REQ-008 SHALL have `ex_branch_taken`  in  1  resolved taken beq/bne in EX.
REQ-009 SHALL have `pc_write`, `ifid_write`  out  1 each  PC and IF/ID load enables.
REQ-010 SHALL have `ifid_flush`, `idex_bubble`  out  1 each  clear IF/ID; load NOP controls into ID/EX.
REQ-011 SHALL have `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data.
REQ-012 SHALL have `stall_count`  out  8  saturating count of stall cycles.

Function
REQ-013 SHALL keep three internal scoreboard slots EX, MEM, WB, each holding {wr, ld, dst[4:0]}.
REQ-014 Each rising edge SHALL shift WB<=MEM and MEM<=EX.
REQ-015 Each rising edge SHALL load EX<={id_reg_write, id_mem_read, id_write_reg}, or all-zero when `idex_bubble`=1.
REQ-016 A slot with dst=0 SHALL be stored with wr=0; register 0 never causes a hazard or a forward.
REQ-017 Hazard match SHALL mean (id_uses_rs && dst==id_rs) || (id_uses_rt && dst==id_rt) against a slot with wr=1.
REQ-018 stall SHALL be combinational: EX slot ld=1 and matching (see Configuration for the no-forwarding rule).
REQ-019 On stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; ID instruction is held.
REQ-020 Jump: id_jump or id_jr with no stall -> ifid_flush=1 for that single cycle.
REQ-021 Jump during stall: a jr or j held by stall SHALL flush only in the cycle its stall clears.
REQ-022 ex_branch_taken=1 SHALL force ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, overriding stall and jump.
REQ-023 Forwarding selects SHALL be registered at the same edge the ID instruction enters EX.
REQ-024 fwd_a=10 if the current EX slot (becoming MEM) matches rs; else 01 if the current MEM slot matches; else 00. fwd_b SHALL use the same rule on rt.
REQ-025 fwd_a/fwd_b SHALL be loaded with 00 when a bubble enters EX.
REQ-026 stall_count SHALL increment on every stall cycle and saturate at 255; no wrap-around.
REQ-027 Outputs SHALL have no latency beyond that stated: stall/flush combinational same cycle; fwd one edge.

Reset
REQ-028 reset SHALL asynchronously clear all slots, fwd_a/fwd_b=00 and stall_count=0.
REQ-029 While reset=1, outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-030 Reset asserted mid-stall SHALL drop the stall immediately; no stale hazard survives deassertion.

Configuration
REQ-031 With `HAZARD_FORWARDING_EN` defined, REQ-018 and REQ-024 apply; a load-use hazard costs exactly one stall cycle.
REQ-032 Without `HAZARD_FORWARDING_EN`, stall SHALL be asserted on any match in the EX or MEM slot regardless of ld.
REQ-033 Without `HAZARD_FORWARDING_EN`, fwd_a/fwd_b SHALL be constant 00. The WB slot never stalls, since the regfile writes first-half.

Verification
REQ-034 Load-use: lw $8 then add $9,$8,$10 (EN) -> one stall cycle (pc_write=0, idex_bubble=1); next edge fwd_a=01; stall_count=1.
REQ-035 ALU-ALU: add $8 then sub $11,$8,$8 (EN) -> no stall; after edge fwd_a=10, fwd_b=10.
REQ-036 No-forwarding: same ALU-ALU pair without macro -> two stall cycles, fwd 00 throughout, stall_count=2.
REQ-037 Branch override: stall active and ex_branch_taken=1 same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1.
REQ-038 jr after lw $31 (EN) -> one stall cycle with ifid_flush=0, then ifid_flush=1 for one cycle.
REQ-039 Saturation/reset: 300 forced stall cycles -> stall_count=255; assert reset mid-stall -> stall_count=0, pc_write=1 immediately.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard unit.
// master = pipeline side (drives ID/EX decode info), slave = hazard unit.
`timescale 1ns/1ps
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_reg_write;
    logic        id_mem_read;
    logic [4:0]  id_write_reg;
    logic        id_jump;
    logic        id_jr;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [7:0]  stall_count;
    // Scoreboard contents {EX, MEM, WB}, each {wr, ld, dst[4:0]}, for observation.
    logic [20:0] dbgSlots;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read,
               id_write_reg, id_jump, id_jr, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               stall_count, dbgSlots
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read,
               id_write_reg, id_jump, id_jr, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               stall_count, dbgSlots
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection / forwarding control for a 5-stage MIPS pipeline.
// Optional macro HAZARD_FORWARDING_EN enables EX/MEM and MEM/WB forwarding.
`timescale 1ns/1ps
module hazard_ctrl (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    typedef struct packed {
        logic       wr;
        logic       ld;
        logic [4:0] dst;
    } slotT;

    slotT       exSlot, memSlot, wbSlot;
    logic       exRs, exRt, memRs, memRt;
    logic       hazard, stall, pipeStall;
    logic       pcWrite, ifidWrite, ifidFlush, idexBubble;
    logic [1:0] fwdA, fwdB;
    logic [7:0] stallCnt;

    // dst==0 slots are stored with wr=0, so register 0 can never match here.
    function automatic logic reads(slotT s, logic uses, logic [4:0] r);
        return s.wr && uses && (s.dst == r);
    endfunction

    assign exRs  = reads(exSlot,  hz.id_uses_rs, hz.id_rs);
    assign exRt  = reads(exSlot,  hz.id_uses_rt, hz.id_rt);
    assign memRs = reads(memSlot, hz.id_uses_rs, hz.id_rs);
    assign memRt = reads(memSlot, hz.id_uses_rt, hz.id_rt);

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = exSlot.ld && (exRs || exRt);
`else
    // WB never stalls: the regfile writes in the first half of the cycle.
    assign hazard = exRs || exRt || memRs || memRt;
`endif

    assign stall     = hazard && !reset;
    assign pipeStall = stall && !hz.ex_branch_taken;

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        if (reset) begin
            pcWrite = 1'b1;
        end else if (hz.ex_branch_taken) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else if (stall) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end else if (hz.id_jump || hz.id_jr) begin
            // A jump held by a stall reaches here only once the stall clears.
            ifidFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exSlot  <= '0;
            memSlot <= '0;
            wbSlot  <= '0;
        end else begin
            wbSlot  <= memSlot;
            memSlot <= exSlot;
            if (idexBubble)
                exSlot <= '0;
            else
                exSlot <= {hz.id_reg_write && (hz.id_write_reg != 5'd0),
                           hz.id_mem_read, hz.id_write_reg};
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Selects are captured as the ID instruction moves into EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwdA <= 2'b00;
            fwdB <= 2'b00;
        end else if (idexBubble) begin
            fwdA <= 2'b00;
            fwdB <= 2'b00;
        end else begin
            fwdA <= exRs ? 2'b10 : (memRs ? 2'b01 : 2'b00);
            fwdB <= exRt ? 2'b10 : (memRt ? 2'b01 : 2'b00);
        end
    end
`else
    assign fwdA = 2'b00;
    assign fwdB = 2'b00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stallCnt <= 8'd0;
        else if (pipeStall && (stallCnt != 8'hFF))
            stallCnt <= stallCnt + 8'd1;
    end

    assign hz.pc_write    = pcWrite;
    assign hz.ifid_write  = ifidWrite;
    assign hz.ifid_flush  = ifidFlush;
    assign hz.idex_bubble = idexBubble;
    assign hz.fwd_a       = fwdA;
    assign hz.fwd_b       = fwdB;
    assign hz.stall_count = stallCnt;
    assign hz.dbgSlots    = {exSlot, memSlot, wbSlot};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic,
// checked against an instruction-history reference model through a queue.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  typedef struct {
    int rs;
    int rt;
    bit usesRs;
    bit usesRt;
    bit regWrite;
    bit memRead;
    int wr;
    bit jump;
    bit jr;
    bit br;
  } stimT;

  // One instruction that has left ID (bubbles are records that write nothing).
  typedef struct {
    bit writes;
    bit load;
    int dst;
  } instT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  hazard_ctrl_if hzIf ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hzIf.slave)
  );

  always #5 clk = ~clk;

  // Reference model state: hist[0] is the instruction now in EX, hist[1] in MEM.
  instT        hist[$];
  logic [1:0]  mFwdA = 2'b00;
  logic [1:0]  mFwdB = 2'b00;
  int          mCount = 0;
  bit          lastStall = 0;
  logic [15:0] expQ[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          done = 0;

  function automatic bit producerHits(instT p, bit uses, int r);
    return p.writes && (p.dst != 0) && uses && (p.dst == r);
  endfunction

  function automatic bit readsFrom(instT p, stimT s);
    return producerHits(p, s.usesRs, s.rs) || producerHits(p, s.usesRt, s.rt);
  endfunction

  function automatic logic [1:0] fwdSel(bit uses, int r);
    if (hist.size() > 0 && producerHits(hist[0], uses, r)) return 2'b10;
    if (hist.size() > 1 && producerHits(hist[1], uses, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic applyInputs(input stimT s);
    hzIf.id_rs           = 5'(s.rs);
    hzIf.id_rt           = 5'(s.rt);
    hzIf.id_uses_rs      = s.usesRs;
    hzIf.id_uses_rt      = s.usesRt;
    hzIf.id_reg_write    = s.regWrite;
    hzIf.id_mem_read     = s.memRead;
    hzIf.id_write_reg    = 5'(s.wr);
    hzIf.id_jump         = s.jump;
    hzIf.id_jr           = s.jr;
    hzIf.ex_branch_taken = s.br;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic driveCycle(input stimT s, input bit rst);
    bit hz, pcw, ifw, fl, bub;
    logic [1:0] nA, nB;
    instT entered;
    @(posedge clk);
    #1;
    reset = rst;
    applyInputs(s);
    if (rst) begin
      hist.delete();
      mFwdA = 2'b00;
      mFwdB = 2'b00;
      mCount = 0;
      lastStall = 0;
      expQ.push_back({1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0});
    end else begin
      hz = 0;
`ifdef HAZARD_FORWARDING_EN
      if (hist.size() > 0 && hist[0].load && readsFrom(hist[0], s)) hz = 1;
`else
      for (int k = 0; k < 2 && k < hist.size(); k++)
        if (readsFrom(hist[k], s)) hz = 1;
`endif
      pcw = 1; ifw = 1; fl = 0; bub = 0;
      if (s.br) begin
        fl = 1; bub = 1;
      end else if (hz) begin
        pcw = 0; ifw = 0; bub = 1;
      end else if (s.jump || s.jr) begin
        fl = 1;
      end
      expQ.push_back({pcw, ifw, fl, bub, mFwdA, mFwdB, 8'(mCount)});
      if (hz && !s.br && mCount < 255) mCount++;
`ifdef HAZARD_FORWARDING_EN
      nA = bub ? 2'b00 : fwdSel(s.usesRs, s.rs);
      nB = bub ? 2'b00 : fwdSel(s.usesRt, s.rt);
`else
      nA = 2'b00;
      nB = 2'b00;
`endif
      mFwdA = nA;
      mFwdB = nB;
      entered.writes = bub ? 0 : s.regWrite;
      entered.load   = bub ? 0 : s.memRead;
      entered.dst    = bub ? 0 : s.wr;
      hist.push_front(entered);
      if (hist.size() > 3) void'(hist.pop_back());
      lastStall = hz && !s.br;
    end
  endtask

  // Present an instruction in ID and hold it until the model says it advances.
  task automatic issue(input stimT s);
    int n = 0;
    do begin
      driveCycle(s, 0);
      n++;
    end while (lastStall && n < 6);
  endtask

  function automatic stimT nop();
    stimT s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stimT mk(int rs, int rt, bit ur, bit ut, bit rw, bit mr, int wr,
                              bit j, bit jr, bit br);
    stimT s;
    s = '{rs: rs, rt: rt, usesRs: ur, usesRt: ut, regWrite: rw, memRead: mr,
          wr: wr, jump: j, jr: jr, br: br};
    return s;
  endfunction

  function automatic int randReg();
    int p;
    p = $urandom_range(0, 4);
    return (p == 4) ? 31 : p;
  endfunction

  function automatic stimT randStim();
    stimT s;
    int kind;
    s.rs       = randReg();
    s.rt       = randReg();
    s.usesRs   = ($urandom_range(0, 3) != 0);
    s.usesRt   = ($urandom_range(0, 2) != 0);
    s.memRead  = ($urandom_range(0, 2) == 0);
    s.regWrite = s.memRead ? 1'b1 : ($urandom_range(0, 3) != 0);
    s.wr       = randReg();
    kind       = $urandom_range(0, 9);
    s.jump     = (kind == 0);
    s.jr       = (kind == 1);
    s.br       = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Monitor: compares every cycle's outputs against the queued prediction.
  initial begin
    logic [15:0] e, act;
    forever begin
      @(negedge clk);
      cyc++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        act = {hzIf.pc_write, hzIf.ifid_write, hzIf.ifid_flush, hzIf.idex_bubble,
               hzIf.fwd_a, hzIf.fwd_b, hzIf.stall_count};
        checks++;
        if (act !== e)
          begin
            failures++;
            $display("FAIL outputs cyc=%0d got pcw=%b ifw=%b flush=%b bub=%b fa=%b fb=%b cnt=%0d exp pcw=%b ifw=%b flush=%b bub=%b fa=%b fb=%b cnt=%0d",
                     cyc, act[15], act[14], act[13], act[12], act[11:10], act[9:8], act[7:0],
                     e[15], e[14], e[13], e[12], e[11:10], e[9:8], e[7:0]);
          end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    stimT lw8, add8, alu8, sub8, lw31, jr31, s;
    applyInputs(nop());
    lw8  = mk(29, 0, 1, 0, 1, 1, 8, 0, 0, 0);
    add8 = mk(8, 10, 1, 1, 1, 0, 9, 0, 0, 0);
    alu8 = mk(1, 2, 1, 1, 1, 0, 8, 0, 0, 0);
    sub8 = mk(8, 8, 1, 1, 1, 0, 11, 0, 0, 0);
    lw31 = mk(29, 0, 1, 0, 1, 1, 31, 0, 0, 0);
    jr31 = mk(31, 0, 1, 0, 0, 0, 0, 0, 1, 0);

    driveCycle(nop(), 1);
    driveCycle(nop(), 1);

    // Load-use, ALU-ALU, register-0 producer.
    issue(lw8);  issue(add8); issue(nop()); issue(nop());
    issue(alu8); issue(sub8); issue(nop()); issue(nop());
    issue(mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 0)); issue(mk(0, 0, 1, 1, 1, 0, 5, 0, 0, 0));
    issue(nop()); issue(nop());

    // Branch taken while a load-use stall is pending.
    issue(lw8);
    s = add8; s.br = 1;
    driveCycle(s, 0);
    issue(nop()); issue(nop());

    // jr behind a load of $31, then a plain jump.
    issue(lw31); issue(jr31); issue(nop());
    issue(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); issue(nop()); issue(nop());

    // Drive the stall counter past saturation.
    for (int i = 0; i < 300; i++) begin
      issue(lw8);
      issue(add8);
    end
    issue(nop()); issue(nop());

    // Reset asserted in the middle of a stall.
    issue(lw8);
    driveCycle(add8, 0);
    driveCycle(add8, 1);
    driveCycle(add8, 0);
    issue(nop()); issue(nop());

    // Random traffic: held instructions, raw cycles and occasional resets.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 59) == 0)
        driveCycle(nop(), 1);
      else if ($urandom_range(0, 2) == 0)
        driveCycle(randStim(), 0);
      else
        issue(randStim());
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending predictions, required 0", expQ.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
